lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 22 ++
 rtl/lsu.sv | 121 ++++++++++++
 tb/tb_lsu.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request/response bus between a processor and the load/store unit.
// The master issues requests and the slave (lsu) returns responses.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, sequences a combinational
// read or a single-cycle write strobe to data memory, then returns a
// one-cycle response. All outputs are registered.
module lsu (
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        bus,
    output logic [15:0] read_addr,
    input  logic [31:0] read_data,
    output logic [15:0] write_addr,
    output logic [31:0] write_data,
    output logic        dm_we,
    output logic [15:0] ld_cnt,
    output logic [15:0] st_cnt
);

    // Highest word address that may be accessed; anything above is rejected.
    localparam logic [15:0] MAX_ADDR = 16'hFFFC;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAPT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RESP
    } state_t;

    state_t state;
    logic   we_q;
    logic   err_q;
    logic   addr_bad;

    assign addr_bad = (bus.req_addr > MAX_ADDR);

    // Sequencer: ready is high exactly while idle; the response pulse is
    // registered from the RESP state so it lands the cycle after RESP.
    // An in-flight write strobe keeps its address/data through reset so the
    // falling strobe still commits to the intended location.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            dm_we         <= 1'b0;
            read_addr     <= 16'h0;
            ld_cnt        <= 16'h0;
            st_cnt        <= 16'h0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            if (!dm_we) begin
                write_addr <= 16'h0;
                write_data <= 32'h0;
            end
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        we_q          <= bus.req_we;
                        err_q         <= addr_bad;
                        if (addr_bad) begin
                            state <= RESP;
                        end else if (bus.req_we) begin
                            write_addr <= bus.req_addr;
                            write_data <= bus.req_wdata;
                            state      <= WR_SETUP;
                        end else begin
                            read_addr <= bus.req_addr;
                            state     <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    state <= RD_CAPT;
                end
                RD_CAPT: begin
                    bus.rsp_rdata <= read_data;
                    state         <= RESP;
                end
                WR_SETUP: begin
                    dm_we <= 1'b1;
                    state <= WR_PULSE;
                end
                WR_PULSE: begin
                    dm_we <= 1'b0;
                    state <= WR_HOLD;
                end
                WR_HOLD: begin
                    state <= RESP;
                end
                RESP: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= err_q;
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                    if (err_q) begin
                        if (!we_q) begin
                            bus.rsp_rdata <= 32'h0;
                        end
                    end else if (we_q) begin
                        st_cnt <= st_cnt + 16'd1;
                    end else begin
                        ld_cnt <= ld_cnt + 16'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    dm_we         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a table of directed transactions, hand-written
// reset / back-to-back / wrap sequences, and random traffic checked against a
// transaction-level model (associative-array memory plus counters).
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] read_addr;
    logic [31:0] read_data;
    logic [15:0] write_addr;
    logic [31:0] write_data;
    logic        dm_we;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    lsu_if bus();

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .write_addr (write_addr),
        .write_data (write_data),
        .dm_we      (dm_we),
        .ld_cnt     (ld_cnt),
        .st_cnt     (st_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Data memory: combinational read, commit on the falling write strobe.
    logic [31:0] mem [0:65535] = '{default: 32'h0};
    assign read_data = mem[read_addr];

    // Memory commit on falling dm_we.
    always @(negedge dm_we) mem[write_addr] <= write_data;

    // Transaction-level reference state.
    logic [31:0] ref_mem [logic [15:0]];
    logic [15:0] m_ld;
    logic [15:0] m_st;
    logic [15:0] m_raddr;
    logic [31:0] m_rdata;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        m_ld    = 16'h0;
        m_st    = 16'h0;
        m_raddr = 16'h0;
        m_rdata = 32'h0;
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    // One full transaction: present, handshake, then check every cycle up to the response.
    task automatic apply_stimulus(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                                  output logic got_err, output logic [31:0] got_rdata);
        logic err;
        int   lat;
        err       = (addr > 16'hFFFC);
        lat       = err ? 1 : (we ? 4 : 3);
        got_err   = 1'b0;
        got_rdata = 32'h0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        wait_ready();
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (!err && we) begin
            ref_mem[addr] = wdata;
            m_st++;
        end
        if (!err && !we) begin
            m_raddr = addr;
            m_ld++;
        end
        if (!we) m_rdata = err ? 32'h0 : ref_read(addr);
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check_output("rsp_valid", 32'(bus.rsp_valid), 32'(k == lat));
            check_output("req_ready", 32'(bus.req_ready), 32'(k == lat));
            check_output("dm_we", 32'(dm_we), 32'(!err && we && k == 1));
            if (!err && we && k <= 2) begin
                check_output("write_addr_stable", 32'(write_addr), 32'(addr));
                check_output("write_data_stable", write_data, wdata);
            end
            if (!err && !we && k <= 1) check_output("read_addr", 32'(read_addr), 32'(addr));
        end
        check_output("rsp_err", 32'(bus.rsp_err), 32'(err));
        check_output("rsp_rdata", bus.rsp_rdata, m_rdata);
        check_output("ld_cnt", 32'(ld_cnt), 32'(m_ld));
        check_output("st_cnt", 32'(st_cnt), 32'(m_st));
        check_output("read_addr_hold", 32'(read_addr), 32'(m_raddr));
        if (we) check_output("mem_contents", mem[addr], ref_read(addr));
        got_err   = bus.rsp_err;
        got_rdata = bus.rsp_rdata;
    endtask

    // Main test sequence.
    initial begin
        logic        ge;
        logic [31:0] gr;

        vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 16'hFFFD, 32'h11111111, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 16'hFFFE, 32'h0,        1'b1, 32'h0000_0000};
        vecs[4] = '{1'b1, 16'h0000, 32'hA5A5A5A5, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 16'hFFFC, 32'h0BADF00D, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b0, 16'hFFFC, 32'h0,        1'b0, 32'h0BADF00D};
        vecs[7] = '{1'b0, 16'h0000, 32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[8] = '{1'b0, 16'h0011, 32'h0,        1'b0, 32'h0000_0000};
        vecs[9] = '{1'b0, 16'hFFFF, 32'h0,        1'b1, 32'h0000_0000};

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 32'h0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_output("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check_output("reset_dm_we", 32'(dm_we), 32'd0);
        check_output("reset_read_addr", 32'(read_addr), 32'd0);
        check_output("reset_write_addr", 32'(write_addr), 32'd0);
        check_output("reset_write_data", write_data, 32'd0);
        check_output("reset_ld_cnt", 32'(ld_cnt), 32'd0);
        check_output("reset_st_cnt", 32'(st_cnt), 32'd0);
        rst = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, ge, gr);
            check_output("table_err", 32'(ge), 32'(vecs[i].exp_err));
            check_output("table_rdata", gr, vecs[i].exp_rdata);
        end

        $display("[TB] back-to-back loads with req_valid held");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0010;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_addr = 16'h0000;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check_output("b2b_ready_1", 32'(bus.req_ready), 32'(k == 3));
            check_output("b2b_valid_1", 32'(bus.rsp_valid), 32'(k == 3));
        end
        check_output("b2b_rdata_1", bus.rsp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_output("b2b_read_addr_2", 32'(read_addr), 32'h0000);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check_output("b2b_ready_2", 32'(bus.req_ready), 32'(k == 3));
            check_output("b2b_valid_2", 32'(bus.rsp_valid), 32'(k == 3));
        end
        check_output("b2b_rdata_2", bus.rsp_rdata, 32'hA5A5A5A5);
        m_ld    = m_ld + 16'd2;
        m_raddr = 16'h0000;
        m_rdata = 32'hA5A5A5A5;
        check_output("b2b_ld_cnt", 32'(ld_cnt), 32'(m_ld));

        $display("[TB] store counter wrap");
        @(negedge clk);
        force dut.st_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.st_cnt;
        m_st = 16'hFFFF;
        apply_stimulus(1'b1, 16'h0030, 32'hCAFEF00D, ge, gr);
        check_output("st_cnt_wrap", 32'(st_cnt), 32'h0000);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            logic        rw;
            logic [15:0] a;
            rw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) a = 16'hFFF8 + 16'($urandom_range(0, 7));
            else a = 16'h0100 + 16'($urandom_range(0, 15));
            apply_stimulus(rw, a, $urandom, ge, gr);
        end

        $display("[TB] reset during write strobe");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 32'h12345678;
        wait_ready();
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("rst_mid_dm_we_high", 32'(dm_we), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("rst_mid_dm_we_low", 32'(dm_we), 32'd0);
        check_output("rst_mid_write_addr_held", 32'(write_addr), 32'h0020);
        check_output("rst_mid_write_data_held", write_data, 32'h12345678);
        check_output("rst_mid_mem", mem[16'h0020], 32'h12345678);
        check_output("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst_mid_st_cnt", 32'(st_cnt), 32'd0);
        @(posedge clk);
        #1;
        check_output("rst_mid_write_addr_clr", 32'(write_addr), 32'd0);
        check_output("rst_mid_write_data_clr", write_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        ref_mem[16'h0020] = 32'h12345678;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check_output("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check_output("rst_mid_no_strobe", 32'(dm_we), 32'd0);
        end

        $display("[TB] reset with simultaneous handshake");
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h0010;
        @(posedge clk);
        #1;
        check_output("rst_hs_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst_hs_read_addr", 32'(read_addr), 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_output("rst_hs_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check_output("rst_hs_ld_cnt", 32'(ld_cnt), 32'd0);
        end

        apply_stimulus(1'b0, 16'h0020, 32'h0, ge, gr);
        check_output("load_after_reset", gr, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
